nibble_serial_adder_seq: RTL and testbench
==========================================

# nibble_serial_adder_seq

Multi-cycle sequencer that performs WIDTH-bit add/subtract by time-sharing a single 4-bit prefix adder slice, one nibble per clock, LSB first. It sits beside the ALU as a low-area arithmetic path and is used where a full-width adder is not affordable. Requests and responses use valid/ready handshakes. A carry register chains the nibbles across cycles.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must be a multiple of 4 and at least 8.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- op_sub  in  1  0 = A+B, 1 = A−B; sampled with the request.
- a  in  WIDTH  operand A; sampled with the request.
- b  in  WIDTH  operand B; sampled with the request.
- rsp_valid  out  1  result available; high only in DONE.
- rsp_ready  in  1  consumer accepts the result.
- result  out  WIDTH  sum/difference, registered.
- cout  out  1  final carry. For subtract, 1 means no borrow (A ≥ B unsigned).
- busy  out  1  high in RUN or DONE.
- ovf  out  1  signed overflow. Present only with NIBBLE_SEQ_OVF_EN.

## Operation
- The FSM has three states: IDLE, RUN, DONE. After reset the state is IDLE.
- IDLE
  - req_ready = 1.
  - On req_valid && req_ready:
    - latch a into opa;
    - latch b into opb, or ~b when op_sub = 1;
    - set carry = op_sub and nib_idx = 0;
    - clear result;
    - go to RUN.
- RUN, each cycle:
  - the slice adds opa[4k+3:4k] + opb[4k+3:4k] + carry, where k = nib_idx;
  - the 4-bit sum is written to result[4k+3:4k];
  - carry is updated with the slice carry-out;
  - nib_idx increments.
  - When k = WIDTH/4−1: cout is set to the final carry, ovf is computed, and the FSM goes to DONE.
- DONE
  - rsp_valid = 1; result, cout and ovf are held stable.
  - On rsp_ready, go to IDLE. rsp_valid falls on the next cycle.
- Inputs a, b, op_sub and req_valid are ignored outside IDLE.
- Arithmetic is modulo 2^WIDTH. The nibble counter width is clog2(WIDTH/4).
- Reset at any point (including mid-RUN or in DONE):
  - the operation is aborted;
  - the next state is IDLE;
  - outputs reset to req_ready = 1, rsp_valid = 0, result = 0, cout = 0, busy = 0, ovf = 0.
- req_ready is driven combinationally from the state. rsp_valid, result, cout and ovf are registered.

## Timing
- A request accepted in cycle T gives:
  - RUN in cycles T+1 … T+WIDTH/4;
  - rsp_valid in cycle T+WIDTH/4+1.
  - For WIDTH = 32, rsp_valid is high at T+9.
- A response handshake in cycle R returns the FSM to IDLE in R+1, so the earliest next accept is R+1.
- Minimum issue interval is WIDTH/4+2 cycles.
- There is no combinational path from req_valid to rsp_valid, or from rsp_ready to req_ready within the same state.

## Configuration
- NIBBLE_SEQ_OVF_EN
  - Defined: ovf port exists. ovf = carry into the MSB XOR carry out of the MSB, captured on the last RUN cycle. The slice exposes its bit-3 carry-in for this.
  - Undefined: the ovf port and its logic are absent. All other behaviour is identical.

## Structure
- Package nibble_seq_pkg:
  - state enum type seq_state_t {IDLE, RUN, DONE};
  - constant NIBBLE_W = 4.
- Sub-module nibble_add_cin:
  - 4-bit Kogge-Stone-style prefix adder with carry-in;
  - outputs sum[3:0], cout and c3 (carry into bit 3);
  - purely combinational and instantiated once.

## Test plan
- Add 0x0000_000F + 0x0000_0001 → result 0x0000_0010, cout 0, rsp_valid exactly 9 cycles after accept.
- Add 0xFFFF_FFFF + 0x0000_0001 → result 0x0000_0000, cout 1, ovf 0.
- Subtract 5 − 7 → result 0xFFFF_FFFE, cout 0. Subtract 7 − 5 → result 0x0000_0002, cout 1.
- Add 0x7FFF_FFFF + 0x0000_0001 (OVF_EN) → result 0x8000_0000, ovf 1, cout 0.
- Hold rsp_ready low for 3 cycles in DONE with req_valid high → result stable, req_ready 0, no new accept. Raise rsp_ready → IDLE on the next cycle, then accept.
- Assert rst in the 4th RUN cycle → next cycle IDLE, all outputs at reset values, rsp_valid never asserted for the aborted request.

Source files
------------

// File: rtl/nibble_serial_adder_seq_pkg.sv
// Shared types for the nibble-serial add/subtract sequencer.
// Optional signed-overflow output: NIBBLE_SEQ_OVF_EN.
package nibble_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/nibble_serial_adder_seq_if.sv
// Request/response bundle for the nibble-serial sequencer.
// ovf exists only when NIBBLE_SEQ_OVF_EN is defined.
interface nibble_serial_adder_seq_if #(
  parameter int WIDTH = 32
);

  logic             req_valid;
  logic             req_ready;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             busy;
`ifdef NIBBLE_SEQ_OVF_EN
  logic             ovf;

  modport master (
    output req_valid, op_sub, a, b,
    output rsp_ready,
    input  req_ready, rsp_valid,
    input  result, cout, busy, ovf
  );

  modport slave (
    input  req_valid, op_sub, a, b,
    input  rsp_ready,
    output req_ready, rsp_valid,
    output result, cout, busy, ovf
  );
`else
  modport master (
    output req_valid, op_sub, a, b,
    output rsp_ready,
    input  req_ready, rsp_valid,
    input  result, cout, busy
  );

  modport slave (
    input  req_valid, op_sub, a, b,
    input  rsp_ready,
    output req_ready, rsp_valid,
    output result, cout, busy
  );
`endif

endinterface

// File: rtl/nibble_serial_adder_seq_add.sv
// 4-bit Kogge-Stone prefix adder with carry-in.
// Exposes the carry into bit 3 for overflow detection.
module nibble_add_cin (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout,
  output logic       o_c3
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic       w_g10, w_p10;
  logic       w_g21, w_p21;
  logic       w_g32, w_p32;
  logic       w_c1, w_c2, w_c3;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  assign w_g10 = w_g[1] | (w_p[1] & w_g[0]);
  assign w_p10 = w_p[1] & w_p[0];
  assign w_g21 = w_g[2] | (w_p[2] & w_g[1]);
  assign w_p21 = w_p[2] & w_p[1];
  assign w_g32 = w_g[3] | (w_p[3] & w_g[2]);
  assign w_p32 = w_p[3] & w_p[2];

  // Second prefix level folds in the carry-in.
  assign w_c1 = w_g[0] | (w_p[0] & i_cin);
  assign w_c2 = w_g10 | (w_p10 & i_cin);
  assign w_c3 = w_g21 | (w_p21 & w_c1);

  assign o_cout = w_g32 | (w_p32 & w_c2);
  assign o_c3   = w_c3;
  assign o_sum  = w_p ^ {w_c3, w_c2, w_c1, i_cin};

endmodule

// File: rtl/nibble_serial_adder_seq.sv
// WIDTH-bit add/sub done one nibble per clock, LSB first.
// Optional signed-overflow output: NIBBLE_SEQ_OVF_EN.
module nibble_serial_adder_seq
  import nibble_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  nibble_serial_adder_seq_if.slave bus
);

  localparam int NIB  = WIDTH / NIBBLE_W;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST =
    IDXW'(NIB - 1);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_result;
  logic [IDXW-1:0]  r_idx;
  logic             r_carry;
  logic             r_cout;
  logic             r_rsp_valid;

  logic [3:0] w_na;
  logic [3:0] w_nb;
  logic [3:0] w_sum;
  logic       w_co;
  logic       w_c3;
  logic       w_last;

  assign w_na   = r_opa[{r_idx, 2'b00} +: NIBBLE_W];
  assign w_nb   = r_opb[{r_idx, 2'b00} +: NIBBLE_W];
  assign w_last = (r_idx == LAST);

  nibble_add_cin u_slice (
    .i_a    (w_na),
    .i_b    (w_nb),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_co),
    .o_c3   (w_c3)
  );

`ifdef NIBBLE_SEQ_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (r_state == S_RUN && w_last) begin
      r_ovf <= w_c3 ^ w_co;
    end
  end

  assign bus.ovf = r_ovf;
`else
  logic w_unused_c3;
  assign w_unused_c3 = w_c3;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_opa       <= '0;
      r_opb       <= '0;
      r_result    <= '0;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_cout      <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      unique case (1'b1)
        (r_state == S_IDLE): begin
          if (bus.req_valid) begin
            r_opa    <= bus.a;
            // Subtract as A + ~B + 1.
            r_opb    <= bus.op_sub ? ~bus.b : bus.b;
            r_carry  <= bus.op_sub;
            r_idx    <= '0;
            r_result <= '0;
            r_state  <= S_RUN;
          end
        end
        (r_state == S_RUN): begin
          r_result[{r_idx, 2'b00} +: NIBBLE_W] <= w_sum;
          r_carry <= w_co;
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            r_cout      <= w_co;
            r_rsp_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        (r_state == S_DONE): begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.result    = r_result;
  assign bus.cout      = r_cout;

endmodule

// File: tb/tb_nibble_serial_adder_seq.sv
// Scoreboard bench for nibble_serial_adder_seq (WIDTH = 32).
// Checks ovf too when NIBBLE_SEQ_OVF_EN is defined.
module tb_nibble_serial_adder_seq;

  typedef struct packed {
    logic [31:0] res;
    logic        co;
    logic        ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  int   acc_q[$];
  logic prev_v = 1'b0;

  nibble_serial_adder_seq_if #(.WIDTH(32)) bus();

  nibble_serial_adder_seq #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, req);
    end
  endtask

  function automatic logic get_ovf();
`ifdef NIBBLE_SEQ_OVF_EN
    return bus.ovf;
`else
    return 1'b0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (!bus.req_ready && n < 40) begin
      step();
      n++;
    end
    if (!bus.req_ready)
      chk({nm, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic issue(input logic sub,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] r,
                       input logic co,
                       input logic ov,
                       input logic push);
    exp_t e;
    e.res = r;
    e.co  = co;
    e.ov  = ov;
    if (push) exp_q.push_back(e);
    bus.op_sub    = sub;
    bus.a         = a;
    bus.b         = b;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
  endtask

  // Monitor: latency and result checks against the queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        acc_q.delete();
        prev_v = 1'b0;
      end else begin
        if (bus.req_valid && bus.req_ready)
          acc_q.push_back(cyc);
        if (bus.rsp_valid) begin
          if (!prev_v) begin
            if (acc_q.size() > 0)
              chk("latency",
                  64'(cyc - acc_q.pop_front()), 64'd9);
            else
              chk("rsp_no_accept", 64'd1, 64'd0);
          end
          if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 64'd1, 64'd0);
          end else begin
            chk("result", 64'(bus.result),
                64'(exp_q[0].res));
            chk("cout", 64'(bus.cout),
                64'(exp_q[0].co));
`ifdef NIBBLE_SEQ_OVF_EN
            chk("ovf", 64'(bus.ovf),
                64'(exp_q[0].ov));
`endif
            if (bus.rsp_ready) void'(exp_q.pop_front());
          end
        end
        prev_v = bus.rsp_valid;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.op_sub    = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.rsp_ready = 1'b1;
    step();
    step();
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_cout", 64'(bus.cout), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_ovf", 64'(get_ovf()), 64'd0);
    rst = 1'b0;
    step();

    issue(0, 32'h0000_000F, 32'h0000_0001,
          32'h0000_0010, 0, 0, 1);
    chk("busy_run", 64'(bus.busy), 64'd1);
    chk("ready_run", 64'(bus.req_ready), 64'd0);
    wait_idle("t1");
    issue(0, 32'hFFFF_FFFF, 32'h0000_0001,
          32'h0000_0000, 1, 0, 1);
    wait_idle("t2");
    issue(1, 32'd5, 32'd7,
          32'hFFFF_FFFE, 0, 0, 1);
    wait_idle("t3");
    issue(1, 32'd7, 32'd5,
          32'h0000_0002, 1, 0, 1);
    wait_idle("t4");
    issue(0, 32'h7FFF_FFFF, 32'h0000_0001,
          32'h8000_0000, 0, 1, 1);
    wait_idle("t5");
    issue(1, 32'h8000_0000, 32'h0000_0001,
          32'h7FFF_FFFF, 1, 1, 1);
    wait_idle("t6");
    issue(0, 32'h1234_5678, 32'h9ABC_DEF0,
          32'hACF1_3568, 0, 0, 1);
    wait_idle("t7");
    issue(1, 32'h0000_1234, 32'h0000_1234,
          32'h0000_0000, 1, 0, 1);
    wait_idle("t8");

    // Hold the response while a new request waits.
    bus.rsp_ready = 1'b0;
    issue(0, 32'd3, 32'd4, 32'd7, 0, 0, 1);
    begin
      int n = 0;
      while (!bus.rsp_valid && n < 40) begin
        step();
        n++;
      end
      if (!bus.rsp_valid)
        chk("hold_timeout", 64'd0, 64'd1);
    end
    bus.op_sub    = 1'b1;
    bus.a         = 32'h10;
    bus.b         = 32'h01;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_ready", 64'(bus.req_ready), 64'd0);
      chk("hold_valid", 64'(bus.rsp_valid), 64'd1);
    end
    bus.rsp_ready = 1'b1;
    step();
    chk("post_rsp_ready", 64'(bus.req_ready), 64'd1);
    chk("post_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    begin
      exp_t e;
      e.res = 32'h0000_000F;
      e.co  = 1'b1;
      e.ov  = 1'b0;
      exp_q.push_back(e);
    end
    step();
    bus.req_valid = 1'b0;
    chk("second_busy", 64'(bus.busy), 64'd1);
    wait_idle("t9");

    // Abort mid-RUN; nothing is queued for it.
    issue(0, 32'h1111_1111, 32'h2222_2222,
          32'h0, 0, 0, 0);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_req_ready", 64'(bus.req_ready), 64'd1);
    chk("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("abort_result", 64'(bus.result), 64'd0);
    chk("abort_cout", 64'(bus.cout), 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_ovf", 64'(get_ovf()), 64'd0);
    for (int i = 0; i < 14; i++) step();

    issue(0, 32'h0000_0100, 32'h0000_0200,
          32'h0000_0300, 0, 0, 1);
    wait_idle("t10");
    step();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
